// File: rtl/multiter_pkg.sv
// ============================================================================
// Module : multiter_pkg
// Brief  : Shared types and constants for the iterative shift-add multiplier.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package multiter_pkg;

   localparam int MUL_ITERS = 64;

   typedef logic [63:0]  u64;
   typedef logic [64:0]  u65;
   typedef logic [127:0] u128;
   typedef logic [128:0] u129;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      DOING = 2'd1,
      DONE  = 2'd2
   } mul_state_t;

endpackage

`default_nettype wire

// File: rtl/multiter_negate128.sv
// ============================================================================
// Module : negate128
// Brief  : 128-bit two's-complement negate, passed through when en is low.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module negate128
   import multiter_pkg::*;
(
   input  logic en,
   input  u128  x,
   output u128  y
);

   assign y = en ? (~x + 128'd1) : x;

endmodule

`default_nettype wire

// File: rtl/multiter.sv
// ============================================================================
// Module : multiter
// Brief  : Radix-2 shift-add 64x64 -> 128 multiplier, fixed 65-cycle latency.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module multiter #(
   parameter int MUL_ITERS = multiter_pkg::MUL_ITERS
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          valid,
   input  logic          flush,
   input  logic          signed_a,
   input  logic          signed_b,
   input  logic [63:0]   a,
   input  logic [63:0]   b,
   output logic          busy,
   output logic          done,
   output logic [127:0]  c
);

   import multiter_pkg::*;

   mul_state_t state;
   mul_state_t state_next;
   logic [6:0] count;
   u64         mcand;
   u129        p;
   logic       neg;

   u64         abs_a;
   u64         abs_b;
   u65         partial;
   u129        p_step;
   u128        result;
   logic       accept;

   // Magnitudes wrap 2^63 onto itself, which reads correctly as unsigned.
   assign abs_a  = (signed_a && a[63]) ? (~a + 64'd1) : a;
   assign abs_b  = (signed_b && b[63]) ? (~b + 64'd1) : b;
   assign accept = valid && !flush;

   assign partial = p[0] ? ({1'b0, p[127:64]} + {1'b0, mcand}) : p[128:64];
   assign p_step  = {1'b0, partial, p[63:1]};

   // Result is taken from the post-final-iteration value so it lands in c on entry to DONE.
   negate128 u_negate (
      .en (neg),
      .x  (p_step[127:0]),
      .y  (result)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         count <= 7'd0;
         mcand <= '0;
         p     <= '0;
         neg   <= 1'b0;
         c     <= '0;
      end else begin
         state <= state_next;
         case (state)
            IDLE: begin
               if (accept) begin
                  mcand <= abs_a;
                  p     <= {65'd0, abs_b};
                  neg   <= (signed_a & a[63]) ^ (signed_b & b[63]);
                  count <= 7'(MUL_ITERS);
               end
            end
            DOING: begin
               if (!flush) begin
                  p     <= p_step;
                  count <= count - 7'd1;
                  if (count == 7'd1) begin
                     c <= result;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      state_next = state;
      done       = 1'b0;
      case (state)
         IDLE: begin
            if (accept) begin
               state_next = DOING;
            end
         end
         DOING: begin
            if (flush) begin
               state_next = IDLE;
            end else if (count == 7'd1) begin
               state_next = DONE;
            end
         end
         DONE: begin
            state_next = IDLE;
            done       = !flush;
         end
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

endmodule

`default_nettype wire

// File: tb/tb_multiter.sv
// ============================================================================
// Module : tb_multiter
// Brief  : Self-checking bench for multiter against a wide-arithmetic product model.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_multiter;

   logic         clk = 1'b0;
   logic         reset;
   logic         valid;
   logic         flush;
   logic         signed_a;
   logic         signed_b;
   logic [63:0]  a;
   logic [63:0]  b;
   logic         busy;
   logic         done;
   logic [127:0] c;

   int n_cmp = 0;
   int n_err = 0;

   multiter dut (
      .clk      (clk),
      .reset    (reset),
      .valid    (valid),
      .flush    (flush),
      .signed_a (signed_a),
      .signed_b (signed_b),
      .a        (a),
      .b        (b),
      .busy     (busy),
      .done     (done),
      .c        (c)
   );

   always #5 clk = ~clk;

   // Product of the operands interpreted as integers, truncated to 128 bits.
   function automatic logic [127:0] model(input logic sa, input logic sb,
                                          input logic [63:0] x, input logic [63:0] y);
      logic [127:0] ex;
      logic [127:0] ey;
      ex = sa ? {{64{x[63]}}, x} : {64'd0, x};
      ey = sb ? {{64{y[63]}}, y} : {64'd0, y};
      return ex * ey;
   endfunction

   function automatic logic [63:0] rand_op();
      logic [63:0] v;
      case ($urandom_range(0, 5))
         0:       v = 64'd0;
         1:       v = 64'd1;
         2:       v = 64'hFFFF_FFFF_FFFF_FFFF;
         3:       v = 64'h8000_0000_0000_0000;
         default: v = {$urandom, $urandom};
      endcase
      return v;
   endfunction

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one op in the current cycle (cycle 0); returns after done (or timeout), valid dropped.
   task automatic run_op(input string tag, input logic sa, input logic sb,
                         input logic [63:0] x, input logic [63:0] y);
      logic [127:0] exp;
      int           done_cyc;
      logic         busy_ok;
      exp      = model(sa, sb, x, y);
      signed_a = sa;
      signed_b = sb;
      a        = x;
      b        = y;
      valid    = 1'b1;
      done_cyc = -1;
      busy_ok  = 1'b1;
      for (int k = 1; k <= 70; k++) begin
         step();
         if (k == 1) begin
            a        = {$urandom, $urandom};
            b        = {$urandom, $urandom};
            signed_a = ~sa;
            signed_b = ~sb;
         end
         if (k == 2) valid = 1'b0;
         if (busy !== 1'b1) busy_ok = 1'b0;
         if (done === 1'b1) begin
            done_cyc = k;
            check({tag, " c"}, c, exp);
            break;
         end
      end
      check({tag, " done_cycle"}, 128'(done_cyc), 128'd65);
      check({tag, " busy_1_65"}, 128'(busy_ok), 128'd1);
      step();
      check({tag, " idle_after"}, {126'd0, busy, done}, 128'd0);
      check({tag, " c_hold"}, c, exp);
   endtask

   initial begin
      logic [127:0] prev;
      logic         sa;
      logic         sb;
      logic [63:0]  x;
      logic [63:0]  y;
      int           dcount;
      int           dcyc[2];

      reset = 1'b1; valid = 1'b0; flush = 1'b0;
      signed_a = 1'b0; signed_b = 1'b0; a = '0; b = '0;
      step();
      step();
      check("reset_state", {c, busy, done}, 130'd0);
      reset = 1'b0;
      step();

      run_op("u3x5", 1'b0, 1'b0, 64'd3, 64'd5);
      check("u3x5_lit", c, 128'hF);
      run_op("umax", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      check("umax_lit", c, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
      run_op("sm2x3", 1'b1, 1'b1, -64'sd2, 64'd3);
      check("sm2x3_lit", c, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFA);
      run_op("smin2", 1'b1, 1'b1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000);
      check("smin2_lit", c, 128'h4000_0000_0000_0000_0000_0000_0000_0000);
      run_op("mixed", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
      check("mixed_lit", c, 128'hFFFF_FFFF_FFFF_FFFF_0000_0000_0000_0001);

      // Flush at cycle 10: back to idle, no done, c unchanged.
      prev = c;
      signed_a = 1'b0; signed_b = 1'b0; a = 64'd9; b = 64'd9; valid = 1'b1;
      dcount = 0;
      for (int k = 1; k <= 10; k++) begin
         step();
         if (done === 1'b1) dcount++;
      end
      flush = 1'b1;
      valid = 1'b0;
      step();
      flush = 1'b0;
      check("flush_state", {126'd0, busy, done}, 128'd0);
      check("flush_c", c, prev);
      for (int k = 0; k < 70; k++) begin
         if (done === 1'b1) dcount++;
         step();
      end
      check("flush_no_done", 128'(dcount), 128'd0);
      run_op("u7x6", 1'b0, 1'b0, 64'd7, 64'd6);
      check("u7x6_lit", c, 128'd42);

      for (int i = 0; i < 8; i++) begin
         sa = 1'($urandom);
         sb = 1'($urandom);
         x  = rand_op();
         y  = rand_op();
         run_op($sformatf("rand%0d", i), sa, sb, x, y);
      end

      // Reset mid-operation.
      signed_a = 1'b0; signed_b = 1'b0; a = 64'd11; b = 64'd13; valid = 1'b1;
      for (int k = 1; k <= 30; k++) step();
      reset = 1'b1;
      valid = 1'b0;
      step();
      reset = 1'b0;
      check("rst_mid", {c, busy, done}, 130'd0);
      dcount = 0;
      for (int k = 0; k < 70; k++) begin
         step();
         if (done === 1'b1) dcount++;
      end
      check("rst_no_done", 128'(dcount), 128'd0);

      // Back-to-back with valid held high.
      signed_a = 1'b1; signed_b = 1'b0; a = -64'sd5; b = 64'd100; valid = 1'b1;
      dcount = 0;
      dcyc[0] = -1; dcyc[1] = -1;
      for (int k = 1; k <= 140; k++) begin
         step();
         if (done === 1'b1) begin
            if (dcount < 2) dcyc[dcount] = k;
            if (dcount == 0) begin
               check("b2b_c0", c, model(1'b1, 1'b0, -64'sd5, 64'd100));
               signed_a = 1'b0; signed_b = 1'b1; a = 64'd12345; b = -64'sd3;
            end else begin
               check("b2b_c1", c, model(1'b0, 1'b1, 64'd12345, -64'sd3));
               valid = 1'b0;
            end
            dcount++;
         end
      end
      valid = 1'b0;
      check("b2b_count", 128'(dcount), 128'd2);
      check("b2b_cyc0", 128'(dcyc[0]), 128'd65);
      check("b2b_cyc1", 128'(dcyc[1]), 128'd131);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
